lcd_static_drv: RTL and testbench

LCD_STATIC_DRV -- requirements
Module: lcd_static_drv

---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_static_drv_if.sv | 21 ++
 rtl/lcd_seg7_dec.sv | 29 ++
 rtl/lcd_static_drv.sv | 156 +++++++++++++++
 tb/tb_lcd_static_drv.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the static LCD driver: 7-segment glyphs, the blank
// digit code and the segment bit positions (a=0 .. g=6).
package lcd_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Glyphs are bit-per-segment masks, bit index given by SEG_A..SEG_G
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // True when a digit code shows nothing worth keeping ahead of lower digits
  function automatic logic is_empty_code(input logic [3:0] code);
    return (code == 4'h0) || (code == BLANK_CODE);
  endfunction

endpackage

// File: rtl/lcd_static_drv_if.sv
// Signal bundle for the static LCD driver: digit load handshake, display
// options and the panel drive pins.
interface lcd_static_drv_if;
  logic [15:0] bcd_in;
  logic        load;
  logic        blank_lz;
  logic        blink_en;
  logic        ready;
  logic        lcdcom;
  logic [27:0] lcdseg;

  modport master (
    output bcd_in, load, blank_lz, blink_en,
    input  ready, lcdcom, lcdseg
  );

  modport slave (
    input  bcd_in, load, blank_lz, blink_en,
    output ready, lcdcom, lcdseg
  );
endinterface

// File: rtl/lcd_seg7_dec.sv
// Combinational digit-code to 7-segment glyph decoder.
// Codes 0xA-0xE show "E"; code 0xF shows nothing.
module lcd_seg7_dec
  import lcd_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  // Code to glyph lookup
  always_comb begin
    glyph = GLYPH_BLANK;
    case (code)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE: glyph = GLYPH_E;
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/lcd_static_drv.sv
// Static (1:1 mux) 4-digit LCD driver: square-wave common, XOR-driven
// segments, single-entry pending buffer, leading-zero blanking and blinking.
module lcd_static_drv
  import lcd_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int BLINK_PER = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        blink_en,
  output logic        ready,
  output logic        lcdcom,
  output logic [27:0] lcdseg
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = (BLINK_PER > 1) ? $clog2(BLINK_PER) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PER - 1);

  logic [DW-1:0] div_r;
  logic [BW-1:0] blink_cnt_r;
  logic          blink_off_r;
  logic [15:0]   pend_r;
  logic          pend_full_r;
  logic [15:0]   disp_r;

  logic          tick_s;
  logic          capture_s;
  logic          transfer_s;
  logic          com_next_s;
  logic [DW-1:0] div_next_s;
  logic [15:0]   disp_next_s;
  logic          pend_full_next_s;
  logic [BW-1:0] blink_cnt_next_s;
  logic          blink_off_next_s;
  logic [3:0]    code_s  [4];
  logic [6:0]    glyph_s [4];
  logic [27:0]   lit_s;

  // Next-state logic; outputs are derived from next state so lcdcom and
  // the segment pins always change on the same edge.
  always_comb begin
    tick_s     = (div_r == DIV_LAST);
    capture_s  = load & ready;
    // pend_full_r is the registered flag, so a load accepted in a toggle
    // cycle waits for the following toggle.
    transfer_s = tick_s & pend_full_r;
    div_next_s  = tick_s ? {DW{1'b0}} : div_r + DW'(1);
    com_next_s  = tick_s ? ~lcdcom : lcdcom;
    disp_next_s = transfer_s ? pend_r : disp_r;

    if (capture_s) begin
      pend_full_next_s = 1'b1;
    end else if (transfer_s) begin
      pend_full_next_s = 1'b0;
    end else begin
      pend_full_next_s = pend_full_r;
    end

    blink_cnt_next_s = blink_cnt_r;
    blink_off_next_s = blink_off_r;
    if (!blink_en) begin
      blink_cnt_next_s = {BW{1'b0}};
      blink_off_next_s = 1'b0;
    end else if (tick_s) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_next_s = {BW{1'b0}};
        blink_off_next_s = ~blink_off_r;
      end else begin
        blink_cnt_next_s = blink_cnt_r + BW'(1);
      end
    end else begin
      blink_cnt_next_s = blink_cnt_r;
    end
  end

  // Leading-zero blanking looks at the raw codes of all higher digits
  always_comb begin
    code_s[0] = disp_next_s[3:0];
    code_s[1] = disp_next_s[7:4];
    code_s[2] = disp_next_s[11:8];
    code_s[3] = disp_next_s[15:12];
    if (blank_lz) begin
      if (disp_next_s[15:12] == 4'h0) begin
        code_s[3] = BLANK_CODE;
      end else begin
        code_s[3] = disp_next_s[15:12];
      end
      if ((disp_next_s[11:8] == 4'h0) && is_empty_code(disp_next_s[15:12])) begin
        code_s[2] = BLANK_CODE;
      end else begin
        code_s[2] = disp_next_s[11:8];
      end
      if ((disp_next_s[7:4] == 4'h0) && is_empty_code(disp_next_s[15:12])
          && is_empty_code(disp_next_s[11:8])) begin
        code_s[1] = BLANK_CODE;
      end else begin
        code_s[1] = disp_next_s[7:4];
      end
    end else begin
      code_s[3] = disp_next_s[15:12];
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_dec
    lcd_seg7_dec u_dec (
      .code  (code_s[i]),
      .glyph (glyph_s[i])
    );
  end

  // Off phase of blinking forces every segment unlit
  always_comb begin
    if (blink_off_next_s) begin
      lit_s = 28'h0000000;
    end else begin
      lit_s = {glyph_s[3], glyph_s[2], glyph_s[1], glyph_s[0]};
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r       <= {DW{1'b0}};
      blink_cnt_r <= {BW{1'b0}};
      blink_off_r <= 1'b0;
      pend_r      <= 16'h0000;
      pend_full_r <= 1'b0;
      disp_r      <= 16'hFFFF;
      ready       <= 1'b0;
      lcdcom      <= 1'b0;
      lcdseg      <= 28'h0000000;
    end else begin
      div_r       <= div_next_s;
      blink_cnt_r <= blink_cnt_next_s;
      blink_off_r <= blink_off_next_s;
      if (capture_s) begin
        pend_r <= bcd_in;
      end else begin
        pend_r <= pend_r;
      end
      pend_full_r <= pend_full_next_s;
      disp_r      <= disp_next_s;
      ready       <= ~pend_full_next_s;
      lcdcom      <= com_next_s;
      // Lit segment is driven opposite to common, unlit follows it
      lcdseg      <= {28{com_next_s}} ^ lit_s;
    end
  end

endmodule

// File: tb/tb_lcd_static_drv.sv
// Directed self-checking bench for lcd_static_drv with CLK_DIV=4, BLINK_PER=2.
module tb_lcd_static_drv;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;

  lcd_static_drv_if bus ();

  lcd_static_drv #(.CLK_DIV(4), .BLINK_PER(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bus.bcd_in),
    .load     (bus.load),
    .blank_lz (bus.blank_lz),
    .blink_en (bus.blink_en),
    .ready    (bus.ready),
    .lcdcom   (bus.lcdcom),
    .lcdseg   (bus.lcdseg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; lcdcom inverts whenever cyc reaches a multiple of 4
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_toggle();
    while (cyc % 4 != 0) step();
  endtask

  function automatic logic exp_com();
    return logic'((cyc / 4) % 2);
  endfunction

  function automatic logic [27:0] exp_seg(input logic [27:0] lit);
    return {28{exp_com()}} ^ lit;
  endfunction

  task automatic do_load(input logic [15:0] v);
    wait_toggle();
    bus.bcd_in = v;
    bus.load   = 1'b1;
    step();
    bus.load   = 1'b0;
    wait_toggle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++;
    if (bus.lcdcom !== 1'b0 || bus.lcdseg !== 28'h0000000 || bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: com=%b seg=%h ready=%b want 0/0000000/0", bus.lcdcom, bus.lcdseg, bus.ready);
    end
    rst = 1'b0;
    cyc = 0;
    step();
    tests++;
    if (bus.ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b want 1", bus.ready);
    end
    for (int k = 0; k < 11; k++) begin
      tests++;
      if (bus.lcdcom !== exp_com() || bus.lcdseg !== {28{exp_com()}}) begin
        fails++;
        $display("FAIL reset_com cyc=%0d: com=%b seg=%h want com=%b seg all equal", cyc, bus.lcdcom, bus.lcdseg, exp_com());
      end
      step();
    end
  endtask

  task automatic test_load();
    logic [27:0] lit;
    lit = {7'h06, 7'h5B, 7'h4F, 7'h66};
    wait_toggle();
    bus.bcd_in = 16'h1234;
    bus.load   = 1'b1;
    step();
    bus.load   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (bus.ready !== 1'b0) begin
        fails++;
        $display("FAIL load_busy k=%0d: ready=%b want 0", k, bus.ready);
      end
      if (k < 2) step();
    end
    step();
    tests++;
    if (bus.ready !== 1'b1 || bus.lcdseg !== exp_seg(lit)) begin
      fails++;
      $display("FAIL load_show: ready=%b seg=%h want 1 %h", bus.ready, bus.lcdseg, exp_seg(lit));
    end
    tests++;
    if (bus.lcdseg[6:0] !== ({7{exp_com()}} ^ 7'b1100110)) begin
      fails++;
      $display("FAIL load_digit0: got %b want %b", bus.lcdseg[6:0], {7{exp_com()}} ^ 7'b1100110);
    end
  endtask

  task automatic test_blanking();
    logic [15:0] vec [6];
    logic        blz [6];
    logic [27:0] lit [6];
    vec[0] = 16'h0070; blz[0] = 1'b0; lit[0] = {7'h3F, 7'h3F, 7'h07, 7'h3F};
    vec[1] = 16'h0070; blz[1] = 1'b1; lit[1] = {7'h00, 7'h00, 7'h07, 7'h3F};
    vec[2] = 16'hF005; blz[2] = 1'b1; lit[2] = {7'h00, 7'h00, 7'h00, 7'h6D};
    vec[3] = 16'h0000; blz[3] = 1'b1; lit[3] = {7'h00, 7'h00, 7'h00, 7'h3F};
    vec[4] = 16'h0B09; blz[4] = 1'b1; lit[4] = {7'h00, 7'h79, 7'h3F, 7'h6F};
    vec[5] = 16'h0800; blz[5] = 1'b0; lit[5] = {7'h3F, 7'h7F, 7'h3F, 7'h3F};
    for (int i = 0; i < 6; i++) begin
      bus.blank_lz = blz[i];
      do_load(vec[i]);
      tests++;
      if (bus.lcdseg !== exp_seg(lit[i])) begin
        fails++;
        $display("FAIL blank_%0d bcd=%h blz=%b: seg=%h want %h", i, vec[i], blz[i], bus.lcdseg, exp_seg(lit[i]));
      end
    end
    // blank_lz change takes effect between toggles
    do_load(16'h0070);
    bus.blank_lz = 1'b1;
    step();
    tests++;
    if (bus.lcdseg !== exp_seg(lit[1])) begin
      fails++;
      $display("FAIL blank_live: seg=%h want %h", bus.lcdseg, exp_seg(lit[1]));
    end
    bus.blank_lz = 1'b0;
  endtask

  task automatic test_ignored_load();
    logic [27:0] lit;
    lit = {7'h06, 7'h5B, 7'h4F, 7'h66};
    wait_toggle();
    bus.bcd_in = 16'h1234;
    bus.load   = 1'b1;
    step();
    bus.bcd_in = 16'h5678;
    step();
    step();
    tests++;
    if (bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL ignore_ready: got %b want 0", bus.ready);
    end
    bus.load = 1'b0;
    wait_toggle();
    tests++;
    if (bus.lcdseg !== exp_seg(lit)) begin
      fails++;
      $display("FAIL ignore_show: seg=%h want %h", bus.lcdseg, exp_seg(lit));
    end
  endtask

  task automatic test_blink();
    logic [27:0] lit;
    logic [27:0] want;
    int          k0;
    lit = {7'h06, 7'h5B, 7'h4F, 7'h66};
    wait_toggle();
    k0 = cyc;
    bus.blink_en = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      want = ((((cyc - k0) / 4) / 2) % 2 == 0) ? exp_seg(lit) : exp_seg(28'h0000000);
      tests++;
      if (bus.lcdseg !== want) begin
        fails++;
        $display("FAIL blink k=%0d: seg=%h want %h", k, bus.lcdseg, want);
      end
    end
    bus.blink_en = 1'b0;
    step();
    tests++;
    if (bus.lcdseg !== exp_seg(lit)) begin
      fails++;
      $display("FAIL blink_off_release: seg=%h want %h", bus.lcdseg, exp_seg(lit));
    end
  endtask

  task automatic test_reset_mid();
    wait_toggle();
    bus.bcd_in = 16'h9999;
    bus.load   = 1'b1;
    step();
    bus.load   = 1'b0;
    step();
    tests++;
    if (bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL rmid_pending: ready=%b want 0", bus.ready);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (bus.lcdcom !== 1'b0 || bus.lcdseg !== 28'h0000000 || bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL rmid_async: com=%b seg=%h ready=%b want 0/0000000/0", bus.lcdcom, bus.lcdseg, bus.ready);
    end
    step();
    step();
    rst = 1'b0;
    cyc = 0;
    step();
    tests++;
    if (bus.ready !== 1'b1 || bus.lcdcom !== 1'b0 || bus.lcdseg !== 28'h0000000) begin
      fails++;
      $display("FAIL rmid_release: ready=%b com=%b seg=%h want 1/0/0000000", bus.ready, bus.lcdcom, bus.lcdseg);
    end
    wait_toggle();
    tests++;
    if (bus.lcdcom !== 1'b1 || bus.lcdseg !== 28'hFFFFFFF || bus.ready !== 1'b1) begin
      fails++;
      $display("FAIL rmid_discard: com=%b seg=%h ready=%b want 1/fffffff/1", bus.lcdcom, bus.lcdseg, bus.ready);
    end
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    cyc          = 0;
    rst          = 1'b1;
    bus.bcd_in   = 16'h0000;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;
    bus.blink_en = 1'b0;
    test_reset();
    test_load();
    test_blanking();
    test_ignored_load();
    test_blink();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
